// File: rtl/b2b_sched_pkg.sv
// ---------------------------------------------------------------------------
// b2b_sched_pkg
// Shared types and constants for the board2board FIFO read scheduler.
//   bucket_t   : 3-bit occupancy bucket (0 = nearly empty .. 4 = nearly full)
//   BKT_TH*    : read-count thresholds that separate the buckets
//   state_t    : scheduler FSM states
//   bucket_of  : maps a FIFO read count onto its bucket
// ---------------------------------------------------------------------------
package b2b_sched_pkg;

   typedef logic [2:0] bucket_t;

   localparam int unsigned BKT_TH1 = 8;
   localparam int unsigned BKT_TH2 = 16;
   localparam int unsigned BKT_TH3 = 32;
   localparam int unsigned BKT_TH4 = 48;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // Saturating bucket map: anything at or above the top threshold stays in
   // bucket 4, so very full FIFOs never wrap back to a low priority.
   function automatic bucket_t bucket_of(input int unsigned count);
      if (count >= BKT_TH4)      return 3'd4;
      else if (count >= BKT_TH3) return 3'd3;
      else if (count >= BKT_TH2) return 3'd2;
      else if (count >= BKT_TH1) return 3'd1;
      else                       return 3'd0;
   endfunction

endpackage

// File: rtl/b2b_rr_bucket_pick.sv
// ---------------------------------------------------------------------------
// b2b_rr_bucket_pick
// Combinational grant selection for the FIFO read scheduler.
//   i_eligible     : FIFOs holding at least one complete event
//   i_buckets      : packed 3-bit bucket per FIFO (FIFO i at [i*3 +: 3])
//   i_starved      : FIFOs whose starvation counter reached the limit
//   i_rr_ptr       : round-robin start index
//   o_grant        : selected FIFO index
//   o_grant_valid  : at least one FIFO is eligible
// ---------------------------------------------------------------------------
module b2b_rr_bucket_pick
   import b2b_sched_pkg::*;
#(
   parameter int NUM_FIFOS = 4,
   parameter int IDX_W     = 2
) (
   input  logic [NUM_FIFOS-1:0]   i_eligible,
   input  logic [NUM_FIFOS*3-1:0] i_buckets,
   input  logic [NUM_FIFOS-1:0]   i_starved,
   input  logic [IDX_W-1:0]       i_rr_ptr,
   output logic [IDX_W-1:0]       o_grant,
   output logic                   o_grant_valid
);

   bucket_t          w_best;
   logic             w_starve_hit;
   logic [IDX_W-1:0] w_starve_idx;
   logic [IDX_W-1:0] w_rr_idx;

   // Highest bucket occupied by any eligible FIFO.
   always_comb begin
      w_best = '0;
      for (int i = 0; i < NUM_FIFOS; i++) begin
         if (i_eligible[i] && (i_buckets[i*3 +: 3] > w_best)) begin
            w_best = i_buckets[i*3 +: 3];
         end
      end
   end

   // Lowest-index starved FIFO; scanning downward lets the lowest win.
   always_comb begin
      w_starve_hit = 1'b0;
      w_starve_idx = '0;
      for (int i = NUM_FIFOS - 1; i >= 0; i--) begin
         if (i_eligible[i] && i_starved[i]) begin
            w_starve_hit = 1'b1;
            w_starve_idx = IDX_W'(i);
         end
      end
   end

   // First eligible FIFO in the best bucket at or after the round-robin
   // pointer. The wrap is an explicit compare-and-subtract so that a
   // FIFO count that is not a power of two still wraps correctly.
   always_comb begin
      w_rr_idx = '0;
      for (int k = NUM_FIFOS - 1; k >= 0; k--) begin
         int idx;
         idx = int'(i_rr_ptr) + k;
         if (idx >= NUM_FIFOS) idx = idx - NUM_FIFOS;
         if (i_eligible[idx] && (i_buckets[idx*3 +: 3] == w_best)) begin
            w_rr_idx = IDX_W'(idx);
         end
      end
   end

   assign o_grant       = w_starve_hit ? w_starve_idx : w_rr_idx;
   assign o_grant_valid = |i_eligible;

endmodule

// File: rtl/b2b_fifo_read_scheduler.sv
// ---------------------------------------------------------------------------
// b2b_fifo_read_scheduler
// Picks one of NUM_FIFOS cluster FIFOs (fullest bucket first, round-robin
// within a bucket, starvation override) and streams one complete event
// from it onto a registered valid/ready output, then re-arbitrates.
//   i_clk, i_rst          : clock, async active-high reset
//   i_flush               : synchronous clear
//   i_fifo_rd_count       : per-FIFO occupancy, FIFO_DEPTH_BITS+1 bits each
//   i_evt_available       : per-FIFO "holds a complete event"
//   i_fifo_empty          : per-FIFO empty flag
//   i_fifo_dout/i_fifo_eoe: per-FIFO first-word-fall-through word + eoe
//   o_fifo_rd_en          : one-hot pop
//   o_out_data/eoe/src    : registered output word, end flag, source FIFO
//   o_out_valid/i_out_ready: output handshake
//   o_busy                : an event is being streamed
// ---------------------------------------------------------------------------
module b2b_fifo_read_scheduler
   import b2b_sched_pkg::*;
#(
   parameter int NUM_FIFOS       = 4,
   parameter int FIFO_DEPTH_BITS = 6,
   parameter int DATA_W          = 64,
   parameter int STARVE_LIMIT    = 8,
   parameter int IDX_W           = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
) (
   input  logic                                   i_clk,
   input  logic                                   i_rst,
   input  logic                                   i_flush,
   input  logic [NUM_FIFOS*(FIFO_DEPTH_BITS+1)-1:0] i_fifo_rd_count,
   input  logic [NUM_FIFOS-1:0]                   i_evt_available,
   input  logic [NUM_FIFOS-1:0]                   i_fifo_empty,
   input  logic [NUM_FIFOS*DATA_W-1:0]            i_fifo_dout,
   input  logic [NUM_FIFOS-1:0]                   i_fifo_eoe,
   output logic [NUM_FIFOS-1:0]                   o_fifo_rd_en,
   output logic [DATA_W-1:0]                      o_out_data,
   output logic                                   o_out_eoe,
   output logic [IDX_W-1:0]                       o_out_src,
   output logic                                   o_out_valid,
   input  logic                                   i_out_ready,
   output logic                                   o_busy
);

   localparam int CNT_W = FIFO_DEPTH_BITS + 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

   state_t             r_state;
   logic [IDX_W-1:0]   r_grant;
   logic [IDX_W-1:0]   r_rr_ptr;
   logic [STV_W-1:0]   r_starve [NUM_FIFOS];
   logic [DATA_W-1:0]  r_out_data;
   logic               r_out_eoe;
   logic [IDX_W-1:0]   r_out_src;
   logic               r_out_valid;

   logic [NUM_FIFOS*3-1:0] w_buckets;
   logic [NUM_FIFOS-1:0]   w_starved;
   logic [IDX_W-1:0]       w_grant;
   logic                   w_grant_valid;
   logic                   w_pop;

   // Per-FIFO bucket and starvation flags feeding the picker.
   always_comb begin
      w_buckets = '0;
      w_starved = '0;
      for (int i = 0; i < NUM_FIFOS; i++) begin
         w_buckets[i*3 +: 3] = bucket_of(32'(i_fifo_rd_count[i*CNT_W +: CNT_W]));
         w_starved[i]        = (r_starve[i] == STV_MAX);
      end
   end

   b2b_rr_bucket_pick #(
      .NUM_FIFOS (NUM_FIFOS),
      .IDX_W     (IDX_W)
   ) u_pick (
      .i_eligible    (i_evt_available),
      .i_buckets     (w_buckets),
      .i_starved     (w_starved),
      .i_rr_ptr      (r_rr_ptr),
      .o_grant       (w_grant),
      .o_grant_valid (w_grant_valid)
   );

   // Pop the granted FIFO whenever it has data and the output register is
   // free or being drained this cycle.
   assign w_pop        = (r_state == STREAM) && !i_fifo_empty[r_grant] &&
                         (!r_out_valid || i_out_ready);
   assign o_fifo_rd_en = w_pop ? (NUM_FIFOS'(1) << r_grant) : '0;

   // FSM, round-robin pointer and starvation counters. Arbitration only
   // happens in IDLE; the eoe pop returns the FSM to IDLE so the next
   // selection overlaps the drain of the last word.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= IDLE;
         r_grant  <= '0;
         r_rr_ptr <= '0;
         for (int i = 0; i < NUM_FIFOS; i++) r_starve[i] <= '0;
      end else if (i_flush) begin
         r_state  <= IDLE;
         r_grant  <= '0;
         r_rr_ptr <= '0;
         for (int i = 0; i < NUM_FIFOS; i++) r_starve[i] <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant_valid) begin
                  r_grant  <= w_grant;
                  r_state  <= STREAM;
                  r_rr_ptr <= (w_grant == IDX_W'(NUM_FIFOS - 1)) ? '0 : w_grant + 1'b1;
                  for (int i = 0; i < NUM_FIFOS; i++) begin
                     if (IDX_W'(i) == w_grant) begin
                        r_starve[i] <= '0;
                     end else if (i_evt_available[i] && (r_starve[i] != STV_MAX)) begin
                        r_starve[i] <= r_starve[i] + 1'b1;
                     end
                  end
               end
            end
            STREAM: begin
               if (w_pop && i_fifo_eoe[r_grant]) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Output register: loads on every pop, otherwise holds until accepted.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_out_data  <= '0;
         r_out_eoe   <= 1'b0;
         r_out_src   <= '0;
         r_out_valid <= 1'b0;
      end else if (i_flush) begin
         r_out_data  <= '0;
         r_out_eoe   <= 1'b0;
         r_out_src   <= '0;
         r_out_valid <= 1'b0;
      end else if (w_pop) begin
         r_out_data  <= i_fifo_dout[r_grant*DATA_W +: DATA_W];
         r_out_eoe   <= i_fifo_eoe[r_grant];
         r_out_src   <= r_grant;
         r_out_valid <= 1'b1;
      end else if (i_out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign o_out_data  = r_out_data;
   assign o_out_eoe   = r_out_eoe;
   assign o_out_src   = r_out_src;
   assign o_out_valid = r_out_valid;
   assign o_busy      = (r_state == STREAM);

endmodule

// File: doc/b2b_fifo_read_scheduler.md
Name: b2b_fifo_read_scheduler

Overview:
- Schedules reads from NUM_FIFOS cluster FIFOs in the board2board switching path onto one output stream.
- Buckets each FIFO by read count and grants the fullest eligible FIFO, using round-robin within a bucket plus a starvation override.
- Once granted, streams one complete event (through the end-of-event word) from that FIFO with valid/ready backpressure, then re-arbitrates.

Parameters:
- NUM_FIFOS, 4, number of cluster FIFOs (2..32).
- FIFO_DEPTH_BITS, 6, FIFO read count width is FIFO_DEPTH_BITS+1.
- DATA_W, 64, FIFO word width.
- STARVE_LIMIT, 8, number of lost grants before a FIFO is forced to the head.
- IDX_W, $clog2(NUM_FIFOS) (minimum 1), index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear, active-high.
- fifo_rd_count  in  NUM_FIFOS x (FIFO_DEPTH_BITS+1)  per-FIFO occupancy.
- evt_available  in  NUM_FIFOS  FIFO holds at least one complete event.
- fifo_empty  in  NUM_FIFOS  per-FIFO empty flag.
- fifo_dout  in  NUM_FIFOS x DATA_W  first-word-fall-through data.
- fifo_eoe  in  NUM_FIFOS  end-of-event flag, aligned with fifo_dout.
- fifo_rd_en  out  NUM_FIFOS  one-hot pop.
- out_data  out  DATA_W  registered output word.
- out_eoe  out  1  last word of the event.
- out_src  out  IDX_W  source FIFO of out_data.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- busy  out  1  an event is in progress (state != IDLE).

Behaviour:
- Reset (rst, asynchronous) and flush (synchronous) clear everything.
  - State returns to IDLE.
  - fifo_rd_en=0, out_valid=0, out_eoe=0, out_data=0, out_src=0, busy=0.
  - Round-robin pointer resets to 0; all starvation counters reset to 0.
  - flush wins over every other event in the same cycle.
- Bucketing is combinational and saturating; it does not wrap:
  - count<8 -> bucket 0
  - 8..15 -> bucket 1
  - 16..31 -> bucket 2
  - 32..47 -> bucket 3
  - >=48 -> bucket 4
- A FIFO is eligible when evt_available[i] is 1.
- Selection, evaluated in IDLE only:
  - If any eligible FIFO has starve_cnt == STARVE_LIMIT, grant the lowest such index.
  - Otherwise take the highest non-empty bucket.
  - Within that bucket, grant the first eligible index at or after rr_ptr, wrapping modulo NUM_FIFOS.
  - With no eligible FIFO, stay in IDLE.
- On grant g:
  - Register g; state -> STREAM on the next edge.
  - rr_ptr <= (g+1) mod NUM_FIFOS.
  - starve_cnt[g] <= 0.
  - Every other eligible FIFO increments its starve_cnt, saturating at STARVE_LIMIT.
- STREAM:
  - fifo_rd_en[g] = !fifo_empty[g] && (!out_valid || out_ready).
  - Each pop loads out_data/out_eoe from fifo_dout[g]/fifo_eoe[g], sets out_src=g and out_valid=1.
  - out_valid clears when out_ready is high and no pop occurs in that cycle.
- End of event: the pop of a word with fifo_eoe=1 moves state to IDLE on the next edge; no further pops from g occur.
- Latency:
  - Eligible in IDLE at cycle N -> STREAM at N+1 -> first pop at N+1 -> out_valid at N+2.
  - Back-to-back events: the next IDLE selection overlaps the drain of the eoe word.
- Boundary conditions:
  - fifo_empty[g] mid-event: stall in STREAM and hold out_valid/out_data.
  - out_ready low: no pop; all outputs hold.
  - evt_available[g] deasserting mid-event is ignored.
  - A single-word event (eoe on the first word) completes in 1 STREAM cycle.
  - NUM_FIFOS not a power of 2: the rr_ptr wrap uses an explicit compare, not bit truncation.

Decomposition:
- Package b2b_sched_pkg holds:
  - bucket typedef (3 bits);
  - bucket threshold constants 8/16/32/48;
  - state enum {IDLE, STREAM}.
- One sub-module, b2b_rr_bucket_pick: combinational.
  - Inputs: eligible mask, buckets, starvation mask, rr_ptr.
  - Outputs: grant index and grant_valid.
- The top level holds the FSM, counters and output register.

Test Plan:
- Single FIFO: FIFO 2 holds a 3-word event, out_ready=1 -> fifo_rd_en=4'b0100 for 3 cycles; out_src=2 on all words; out_eoe on word 3; busy drops the following cycle.
- Bucket priority: counts {5,20,50,10}, all eligible -> FIFO 2 granted first.
- Round-robin: counts {10,12,9,14} (all bucket 1), rr_ptr=0, one word per event -> grants 0,1,2,3,0 across successive events.
- Backpressure and underflow: out_ready low for 4 cycles mid-event, then fifo_empty[g] for 2 cycles -> no pops; out_data stable; the event completes intact with word order preserved.
- Starvation: FIFO 0 at count 5 eligible, FIFO 1 kept at count 60, STARVE_LIMIT=8 -> FIFO 0 is granted on the 9th arbitration.
- Reset/flush mid-event: rst asserted asynchronously during STREAM -> all outputs 0 immediately; flush behaves the same at the next edge; the next grant follows the rr_ptr=0 order.
